// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: processes one bit per clock, LSB first,
// and publishes Diff/Borrow together with a single-cycle Done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Start,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic a0, b0, bit_d, br_next;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign bit_d   = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the first (LSB) bit lands at bit 0.
        res_d = {bit_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Diff   = diff_q;
  assign Borrow = borrow_q;
  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == DONE);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor with a start/done handshake. It is the inverse-operation companion to the team's registered parallel adder.
- Computes Diff = A - B (mod 2^WIDTH) and a Borrow flag, one bit per clock, LSB first.
- Intended for area-constrained datapaths where a WIDTH-cycle latency is acceptable. Sits between operand registers and a consumer that waits for Done.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  minuend, sampled only on the accepting Start edge
- B  input  WIDTH  subtrahend, sampled only on the accepting Start edge
- Start  input  1  request a new subtraction, accepted only in IDLE
- Diff  output  WIDTH  registered result (A - B) mod 2^WIDTH
- Borrow  output  1  registered borrow-out, 1 iff A < B (unsigned)
- Busy  output  1  high while state is RUN
- Done  output  1  single-cycle pulse, result valid

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; Diff=0, Borrow=0, Busy=0, Done=0; shift registers, bit counter and internal borrow cleared. Takes effect immediately, including mid-operation. The in-flight operation is discarded and no Done is issued.
- States: IDLE, RUN, DONE.
- IDLE, Start=1 at an edge:
  - latch A and B into operand shift registers
  - clear the internal borrow br and the bit counter cnt (width clog2(WIDTH)+1)
  - go to RUN
- IDLE, Start=0: remain in IDLE.
- RUN, each edge, on the current LSBs a0/b0:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into the result shift register from the MSB end
  - shift the operands right by 1
  - cnt += 1
- RUN exit: on the edge where cnt reaches WIDTH-1 (the WIDTH-th bit is processed):
  - Diff <= final result vector, including that bit
  - Borrow <= br_next
  - go to DONE
- DONE: Done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Busy = (state == RUN). Done = (state == DONE). Both are decoded from registered state, so there are no combinational paths from inputs to outputs.
- Latency: Start sampled at edge N -> Done high in the cycle after edge N+WIDTH. Total of WIDTH+1 cycles from Start acceptance to Done.
- Minimum spacing between accepted Starts is WIDTH+2 cycles; a Start held high continuously yields back-to-back operations at that rate.
- Start while in RUN or DONE is ignored and has no effect on the operation in flight. A and B may change freely after acceptance without affecting the result.
- Diff and Borrow hold their last value until the next operation's DONE transition; they never show partial results.
- Arithmetic: unsigned only; Diff wraps modulo 2^WIDTH. Borrow == 1 exactly when the true difference is negative.
- Reset deasserted while Start=1: no operation is accepted until the first rising edge with Rst_n high.

Test Plan:
- Reset, then A=9, B=3, Start 1 cycle -> Busy for 4 cycles, Done 1-cycle pulse 5 cycles after the accepting edge, Diff=6, Borrow=0.
- A=3, B=9 -> Diff=4'hA, Borrow=1. A=0, B=1 -> Diff=4'hF, Borrow=1. A=15, B=15 -> Diff=0, Borrow=0.
- Start pulsed with A=5, B=2; Start re-pulsed with A=1, B=7 during RUN and during DONE -> exactly one Done, Diff=3, Borrow=0. Operands changed during RUN do not alter the result.
- Start held high 20 cycles with constant A=12, B=4 -> Done pulses every 6 cycles, each with Diff=8, Borrow=0.
- Rst_n pulsed low mid-RUN (after 2 bits processed) -> all outputs 0 immediately, no Done. A following operation A=7, B=2 gives Diff=5.
- Exhaustive sweep of all 256 A/B pairs at WIDTH=4, plus random pairs at WIDTH=8 -> Diff and Borrow match a reference model for every pair.
